// File: rtl/alu_pipe.sv
// alu_pipe: registered EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops (AND/OR/ADD/SUB/NOR/SLT/SLL/SRL/SRA) return one cycle after accept.
// MUL runs an iterative shift-add multiplier (low WIDTH bits, unsigned).
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready          input handshake for a, b, alu_op
//   out_valid/out_ready        output handshake for result and flags
//   result                     registered result
//   zero, negative             derived from the registered result
//   carry, overflow            ADD carry-out / SUB borrow, signed overflow (ADD/SUB only)
//   illegal_op                 opcode not recognised (result forced to 0)
module alu_pipe #(
    parameter int unsigned WIDTH = 64,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0011;
    localparam logic [3:0] OpSrl = 4'b0100;
    localparam logic [3:0] OpSra = 4'b0101;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpMul = 4'b1000;
    localparam logic [3:0] OpNor = 4'b1100;

    typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

    state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW:0]     count_q, count_d;

    logic             accept;
    logic             take;
    logic             mul_done;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    assign accept   = in_valid & in_ready;
    assign take     = out_valid_q & out_ready;
    assign mul_done = (count_q == (SHW+1)'(WIDTH));
    assign shamt    = b[SHW-1:0];

    // Single-cycle ALU on the live operands.
    always_comb begin
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (alu_op)
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpNor: alu_res = ~(a | b);
            OpAdd: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = sum_sub[WIDTH-1:0];
                // No carry out of a + ~b + 1 means a < b unsigned.
                alu_c   = ~sum_sub[WIDTH];
                alu_v   = (a[WIDTH-1] == ~b[WIDTH-1]) & (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSll: alu_res = a << shamt;
            OpSrl: alu_res = a >> shamt;
            OpSra: alu_res = $unsigned($signed(a) >>> shamt);
            OpMul: alu_res = '0;  // produced by the multiplier
            default: alu_ill = 1'b1;
        endcase
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && alu_op == OpMul) state_d = StMul;
            StMul:   if (mul_done) state_d = StHold;
            StHold:  if (take) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs. MUL can only be accepted when the output slot is empty or
    // being emptied, so a held older result is never overwritten by the product.
    always_comb begin
        in_ready = (state_q == StIdle) & (~out_valid_q | out_ready) & ~reset;
    end

    // Datapath next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;

        if (take) out_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (alu_op == OpMul) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        count_d  = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        carry_d     = alu_c;
                        ovf_d       = alu_v;
                        ill_d       = alu_ill;
                    end
                end
            end
            StMul: begin
                if (!mul_done) begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    result_d    = acc_q;
                    zero_d      = (acc_q == '0);
                    neg_d       = acc_q[WIDTH-1];
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign carry      = carry_q;
    assign overflow   = ovf_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: scoreboard of expected results pushed at accept
// and popped when the DUT hands a result over.
module tb_alu_pipe;

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [3:0]  alu_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        zero, negative, carry, overflow, illegal_op;

    int   errors = 0;
    int   checks = 0;
    int   pushes = 0;
    int   pops = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    alu_pipe #(.WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [63:0] x,
                                   input logic [63:0] y);
        exp_t        e;
        logic [64:0] s;
        e = '0;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b1100: e.res = ~(x | y);
            4'b0010: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[63:0];
                e.c   = s[64];
                e.v   = (x[63] == y[63]) && (e.res[63] != x[63]);
            end
            4'b0110: begin
                e.res = x - y;
                e.c   = (x < y);
                e.v   = (x[63] != y[63]) && (e.res[63] != x[63]);
            end
            4'b0111: e.res = {63'd0, ($signed(x) < $signed(y))};
            4'b0011: e.res = x << y[5:0];
            4'b0100: e.res = x >> y[5:0];
            4'b0101: e.res = $unsigned($signed(x) >>> y[5:0]);
            4'b1000: e.res = x * y;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 64'd0);
        e.n = e.res[63];
        return e;
    endfunction

    // Random backpressure; changes just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end

    // Output monitor: a take happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_extra_result", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                check_eq("result", result, mon_e.res);
                check_eq("zero", 64'(zero), 64'(mon_e.z));
                check_eq("negative", 64'(negative), 64'(mon_e.n));
                check_eq("carry", 64'(carry), 64'(mon_e.c));
                check_eq("overflow", 64'(overflow), 64'(mon_e.v));
                check_eq("illegal_op", 64'(illegal_op), 64'(mon_e.ill));
            end
        end
    end

    // Present one op and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(op, x, y));
                pushes++;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [10];
        int  n;
        bit  seen;
        ops = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0010,
                4'b0110, 4'b0011, 4'b0101, 4'b1001, 4'b1000};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_flags", 64'({zero, negative, carry, overflow, illegal_op}), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // ADD wrap to zero, 1-cycle latency.
        send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check_eq("add_latency", 64'(out_valid), 64'd1);
        // Signed overflow, then borrow.
        send(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        send(4'b0110, 64'd3, 64'd5);

        // MUL latency and in_ready low while busy.
        @(posedge clk);
        #1;
        send(4'b1000, 64'h1234, 64'h10);
        n    = 0;
        seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("mul_latency", 64'(n), 64'd65);
        check_eq("mul_in_ready_low", 64'(seen), 64'd0);
        check_eq("mul_result", result, 64'h12340);
        @(posedge clk);
        #1;

        // Illegal op, SRA fill, shift by zero.
        send(4'b1111, 64'd5, 64'd6);
        send(4'b0101, 64'h8000_0000_0000_0000, 64'd63);
        send(4'b0011, 64'hDEAD_BEEF_0000_0001, 64'd0);
        send(4'b0100, 64'hDEAD_BEEF_0000_0001, 64'd4);

        // Back-to-back stream with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            send(ops[(i < 40) ? (i % 4) : $urandom_range(0, 9)],
                 {$urandom, $urandom}, {$urandom, $urandom});
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
        check_eq("pops_eq_pushes", 64'(pops), 64'(pushes));

        // Reset in the middle of a MUL.
        send(4'b1000, 64'd3, 64'd5);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midmul_rst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        pushes = pops;
        @(posedge clk);
        #1;
        check_eq("midmul_out_valid", 64'(out_valid), 64'd0);
        check_eq("midmul_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midmul_in_ready_after", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("midmul_no_ghost", 64'(seen), 64'd0);
        send(4'b0000, 64'hF0F0, 64'hFF00);
        repeat (3) @(posedge clk);
        #1;
        check_eq("final_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
